pe_address_generator: RTL and testbench
=======================================

PE_ADDRESS_GENERATOR -- requirements
Module: pe_address_generator

Interface
REQ-001 Parameter DEPTH, default 2: width of row/column offset fields.
REQ-002 Parameter A, default 7: local-store address width.
REQ-003 Parameter CH, default 2: number of independent address channels (ch0 = kernel, ch1 = neuron by convention).
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RST_N  input  1  reset, synchronous and active-low.
REQ-006 cfg_we  input  1  configuration write strobe.
REQ-007 cfg_ch  input  max(1,clog2(CH))  target channel of the configuration write.
REQ-008 cfg_sel  input  3  register select: 0 PITCH, 1 COL_STRIDE, 2 ROW_STRIDE, 3 COL_LAST, 4 ROW_LAST, 5 ROW_OFST, 6 COL_OFST, 7 reserved.
REQ-009 cfg_data  input  A  write data; OFST registers take the low DEPTH bits.
REQ-010 cmd_valid  input  CH  per-channel command strobe.
REQ-011 cmd_op  input  2*CH  per-channel opcode, channel c at bits [2c+1:2c]: 00 NOP, 01 START, 10 ADV, 11 ABORT.
REQ-012 addr  output  A*CH  per-channel registered address, channel c at bits [A(c+1)-1:Ac].
REQ-013 addr_valid  output  CH  channel is in RUN and addr is meaningful.
REQ-014 last  output  CH  current addr is the final position of the sweep.
REQ-015 done  output  CH  one-cycle pulse when the sweep completes.
REQ-016 cfg_err  output  1  one-cycle pulse when a config write is rejected.

Function
REQ-017 Each channel is an independent FSM with states IDLE, RUN, DONE; all channels share identical logic.
REQ-018 Per-channel counters row, col: A bits each; address = ((row+ROW_OFST)*PITCH + col + COL_OFST) mod 2^A.
REQ-019 addr, addr_valid and last are registered; they reflect new row/col one cycle after the accepting edge.
REQ-020 START (any state): row=0, col=0, go to RUN; addr_valid=1 from the next cycle; START in RUN restarts the sweep.
REQ-021 ADV in RUN, not last: if col+COL_STRIDE <= COL_LAST, col += COL_STRIDE; else col=0 and row += ROW_STRIDE.
REQ-022 last = 1 when col+COL_STRIDE > COL_LAST and row+ROW_STRIDE > ROW_LAST; compare in A+1 bits, no wrap.
REQ-023 ADV in RUN while last=1: go to DONE, addr_valid=0, last=0, done pulses 1 for that next cycle; addr holds its final value.
REQ-024 ADV or NOP in IDLE/DONE: no effect; ABORT in any state: go to IDLE, addr_valid=0, last=0, no done pulse.
REQ-025 A stride register holding 0 is treated as 1.
REQ-026 cfg write to a channel in RUN is ignored and cfg_err pulses next cycle; writes to IDLE/DONE channels take effect next cycle.
REQ-027 cfg_sel=7 or cfg_ch >= CH: write ignored, cfg_err pulses.
REQ-028 Same-cycle cfg write and START on one IDLE channel: START uses the old value; the write still commits.
REQ-029 cmd_valid=0 means NOP regardless of cmd_op.

Reset
REQ-030 RST_N=0 at a rising edge, including mid-sweep: all channels to IDLE, row=col=0, addr=0, addr_valid=0, last=0, done=0, cfg_err=0.
REQ-031 Reset values: PITCH=0, COL_STRIDE=1, ROW_STRIDE=1, COL_LAST=0, ROW_LAST=0, ROW_OFST=0, COL_OFST=0.

Verification
REQ-032 ch0 PITCH=8, strides 1, COL_LAST=3, ROW_LAST=1, START then 7 ADV -> addr 0,1,2,3,8,9,10,11; last=1 only on 11; 8th ADV -> done pulse, addr_valid=0.
REQ-033 ch0 COL_STRIDE=2, ROW_STRIDE=2, COL_LAST=3, ROW_LAST=3, PITCH=8 -> addr 0,2,16,18; last on 18.
REQ-034 ch1 PITCH=8, ROW_OFST=1, COL_OFST=2, START -> first addr 10; concurrent ch0 sweep unaffected.
REQ-035 A=7, PITCH=100, ROW_OFST=1, row reaches 1 -> addr = 200 mod 128 = 72.
REQ-036 cfg write to a RUN channel -> cfg_err pulse, sweep addresses unchanged; RST_N=0 mid-sweep -> all outputs 0 next cycle.

Source files
------------

// File: rtl/pe_address_generator.sv
// pe_address_generator
//   Multi-channel 2-D address sweeper for a processing element's local store.
//   Every channel owns its own configuration registers and an IDLE/RUN/DONE
//   state machine that walks a (row, col) grid. Each step emits
//     addr = ((row + ROW_OFST) * PITCH + col + COL_OFST) mod 2^A
//
// Ports
//   CLK, RST_N   clock; synchronous active-low reset
//   cfg_we       configuration write strobe
//   cfg_ch       target channel of the write
//   cfg_sel      register select (0 PITCH .. 6 COL_OFST, 7 reserved)
//   cfg_data     write data (OFST registers keep the low DEPTH bits)
//   cmd_valid    per-channel command strobe
//   cmd_op       per-channel opcode, 2 bits per channel
//   addr         per-channel registered address, A bits per channel
//   addr_valid   channel is running and addr is meaningful
//   last         addr is the final position of the sweep
//   done         one-cycle pulse when a sweep completes
//   cfg_err      one-cycle pulse when a config write is rejected
//   state_dbg    per-channel FSM state, 2 bits per channel (observation only)
//
// Handshake: there is no ready. A command for channel c is taken on every
// rising edge where cmd_valid[c] is 1; cmd_op is ignored otherwise. A config
// write is taken on every edge where cfg_we is 1; a rejected write is
// reported by cfg_err on the following cycle.
module pe_address_generator #(
    parameter int DEPTH = 2,
    parameter int A     = 7,
    parameter int CH    = 2,
    localparam int CW   = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              cfg_we,
    input  logic [CW-1:0]     cfg_ch,
    input  logic [2:0]        cfg_sel,
    input  logic [A-1:0]      cfg_data,
    input  logic [CH-1:0]     cmd_valid,
    input  logic [2*CH-1:0]   cmd_op,
    output logic [A*CH-1:0]   addr,
    output logic [CH-1:0]     addr_valid,
    output logic [CH-1:0]     last,
    output logic [CH-1:0]     done,
    output logic              cfg_err,
    output logic [2*CH-1:0]   state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_ADV   = 2'b10;
    localparam logic [1:0] OP_ABORT = 2'b11;

    logic [CH-1:0] run_mask;
    logic          cfg_reject;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        state_t           state;
        logic [A-1:0]     row, col;
        logic [A-1:0]     pitch, col_stride, row_stride, col_last, row_last;
        logic [DEPTH-1:0] row_ofst, col_ofst;
        logic [A-1:0]     addr_q;
        logic             valid_q, last_q, done_q;

        logic [1:0]       op;
        logic             cfg_hit;
        logic [A-1:0]     cs, rs;
        logic [A:0]       col_step;
        logic [A-1:0]     row_nx, col_nx, rsum, addr_nx;
        logic             last_nx;

        // Next position and the address/last flags that go with it. Config
        // registers are read as they stand before this edge, so a write in
        // the same cycle as START only affects later steps.
        always_comb begin
            op       = cmd_valid[c] ? cmd_op[2*c +: 2] : OP_NOP;
            cfg_hit  = cfg_we && (cfg_ch == CW'(c)) && (cfg_sel != 3'd7)
                       && (state != S_RUN);
            cs       = (col_stride == '0) ? A'(1) : col_stride;
            rs       = (row_stride == '0) ? A'(1) : row_stride;
            col_step = {1'b0, col} + {1'b0, cs};
            row_nx   = row;
            col_nx   = col;
            if (op == OP_START) begin
                row_nx = '0;
                col_nx = '0;
            end else if (op == OP_ADV && state == S_RUN && !last_q) begin
                if (col_step <= {1'b0, col_last}) begin
                    col_nx = col_step[A-1:0];
                end else begin
                    col_nx = '0;
                    row_nx = row + rs;
                end
            end
            rsum    = row_nx + A'(row_ofst);
            addr_nx = rsum * pitch + col_nx + A'(col_ofst);
            // Compared one bit wider so a step past the top never wraps.
            last_nx = (({1'b0, col_nx} + {1'b0, cs}) > {1'b0, col_last})
                   && (({1'b0, row_nx} + {1'b0, rs}) > {1'b0, row_last});
        end

        always_ff @(posedge CLK) begin
            if (!RST_N) begin
                state      <= S_IDLE;
                row        <= '0;
                col        <= '0;
                pitch      <= '0;
                col_stride <= A'(1);
                row_stride <= A'(1);
                col_last   <= '0;
                row_last   <= '0;
                row_ofst   <= '0;
                col_ofst   <= '0;
                addr_q     <= '0;
                valid_q    <= 1'b0;
                last_q     <= 1'b0;
                done_q     <= 1'b0;
            end else begin
                done_q <= 1'b0;
                if (cfg_hit) begin
                    case (cfg_sel)
                        3'd0:    pitch      <= cfg_data;
                        3'd1:    col_stride <= cfg_data;
                        3'd2:    row_stride <= cfg_data;
                        3'd3:    col_last   <= cfg_data;
                        3'd4:    row_last   <= cfg_data;
                        3'd5:    row_ofst   <= cfg_data[DEPTH-1:0];
                        3'd6:    col_ofst   <= cfg_data[DEPTH-1:0];
                        default: ;
                    endcase
                end
                case (op)
                    OP_START: begin
                        state   <= S_RUN;
                        row     <= row_nx;
                        col     <= col_nx;
                        addr_q  <= addr_nx;
                        valid_q <= 1'b1;
                        last_q  <= last_nx;
                    end
                    OP_ADV: begin
                        if (state == S_RUN) begin
                            if (last_q) begin
                                // addr keeps the final position
                                state   <= S_DONE;
                                valid_q <= 1'b0;
                                last_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                row     <= row_nx;
                                col     <= col_nx;
                                addr_q  <= addr_nx;
                                last_q  <= last_nx;
                            end
                        end
                    end
                    OP_ABORT: begin
                        state   <= S_IDLE;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end

        assign run_mask[c]        = (state == S_RUN);
        assign addr[c*A +: A]     = addr_q;
        assign addr_valid[c]      = valid_q;
        assign last[c]            = last_q;
        assign done[c]            = done_q;
        assign state_dbg[2*c +: 2] = state;
    end

    // A write is rejected for the reserved select, a non-existent channel,
    // or a channel that is mid-sweep.
    always_comb begin
        cfg_reject = 1'b0;
        if (cfg_we) begin
            if (cfg_sel == 3'd7 || int'(cfg_ch) >= CH) begin
                cfg_reject = 1'b1;
            end else begin
                cfg_reject = run_mask[cfg_ch];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_reject;
        end
    end

endmodule

// File: tb/tb_pe_address_generator.sv
// Bench for pe_address_generator: directed sweeps from the worked examples
// plus randomized configurations and advance patterns, checked against a
// reference that enumerates the whole sweep as a list of addresses.
module tb_pe_address_generator;

    localparam int DEPTH = 2;
    localparam int A     = 7;
    localparam int CH    = 2;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_ADV   = 2'b10;
    localparam logic [1:0] OP_ABORT = 2'b11;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    // ---------------- clock / reset ----------------
    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic              cfg_we;
    logic [0:0]        cfg_ch;
    logic [2:0]        cfg_sel;
    logic [A-1:0]      cfg_data;
    logic [CH-1:0]     cmd_valid;
    logic [2*CH-1:0]   cmd_op;
    logic [A*CH-1:0]   addr;
    logic [CH-1:0]     addr_valid;
    logic [CH-1:0]     last;
    logic [CH-1:0]     done;
    logic              cfg_err;
    logic [2*CH-1:0]   state_dbg;

    always #5 CLK = ~CLK;

    pe_address_generator #(.DEPTH(DEPTH), .A(A), .CH(CH)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_sel    (cfg_sel),
        .cfg_data   (cfg_data),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .addr       (addr),
        .addr_valid (addr_valid),
        .last       (last),
        .done       (done),
        .cfg_err    (cfg_err),
        .state_dbg  (state_dbg)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard / reference ----------------
    int tests = 0;
    int fails = 0;

    logic [A-1:0] exp_q [CH][$];

    int m_pitch [CH];
    int m_cs    [CH];
    int m_rs    [CH];
    int m_cl    [CH];
    int m_rl    [CH];
    int m_ro    [CH];
    int m_co    [CH];
    int m_state [CH];

    task automatic m_reset();
        for (int c = 0; c < CH; c++) begin
            m_pitch[c] = 0; m_cs[c] = 1; m_rs[c] = 1;
            m_cl[c] = 0;    m_rl[c] = 0; m_ro[c] = 0; m_co[c] = 0;
            m_state[c] = M_IDLE;
        end
    endtask

    function automatic bit cfg_ok(input int ch, input int sel);
        return (sel != 7) && (ch < CH) && (m_state[ch] != M_RUN);
    endfunction

    task automatic cfg_apply(input int ch, input int sel, input int data);
        case (sel)
            0: m_pitch[ch] = data;
            1: m_cs[ch]    = data;
            2: m_rs[ch]    = data;
            3: m_cl[ch]    = data;
            4: m_rl[ch]    = data;
            5: m_ro[ch]    = data % (1 << DEPTH);
            6: m_co[ch]    = data % (1 << DEPTH);
            default: ;
        endcase
    endtask

    // The complete sweep in visiting order: rows outer, columns inner.
    task automatic build_exp(input int ch);
        int cs, rs;
        cs = (m_cs[ch] == 0) ? 1 : m_cs[ch];
        rs = (m_rs[ch] == 0) ? 1 : m_rs[ch];
        exp_q[ch].delete();
        for (int r = 0; r <= m_rl[ch]; r += rs)
            for (int k = 0; k <= m_cl[ch]; k += cs)
                exp_q[ch].push_back(A'(((r + m_ro[ch]) * m_pitch[ch] + k + m_co[ch]) % (1 << A)));
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic cfg_write(input int ch, input int sel, input int data);
        bit ok;
        ok       = cfg_ok(ch, sel);
        cfg_we   = 1'b1;
        cfg_ch   = 1'(ch);
        cfg_sel  = 3'(sel);
        cfg_data = A'(data);
        tick();
        cfg_we = 1'b0;
        check("cfg_err", 32'(cfg_err), 32'(!ok));
        if (ok) cfg_apply(ch, sel, data);
    endtask

    task automatic cmd(input int ch, input logic [1:0] op);
        cmd_op[2*ch +: 2] = op;
        cmd_valid[ch]     = 1'b1;
        tick();
        cmd_valid = '0;
        if (op == OP_START) m_state[ch] = M_RUN;
        if (op == OP_ABORT) m_state[ch] = M_IDLE;
    endtask

    task automatic setup(input int ch, input int pitch, input int cs, input int rs,
                         input int cl, input int rl, input int ro, input int co);
        cfg_write(ch, 0, pitch);
        cfg_write(ch, 1, cs);
        cfg_write(ch, 2, rs);
        cfg_write(ch, 3, cl);
        cfg_write(ch, 4, rl);
        cfg_write(ch, 5, ro);
        cfg_write(ch, 6, co);
    endtask

    // Start the masked channels together and walk them to completion.
    // rand_adv: each running channel advances on a coin flip per cycle.
    // poke_at: cycle index at which a config write to ch0 is attempted.
    task automatic sweep(input logic [CH-1:0] mask, input bit rand_adv, input int poke_at);
        logic [CH-1:0] run;
        logic [CH-1:0] adv;
        logic [A-1:0]  fin;
        int step, psel, pdata;
        bit poke, poke_ok;
        for (int c = 0; c < CH; c++) begin
            if (mask[c]) build_exp(c);
            cmd_op[2*c +: 2] = OP_START;
        end
        cmd_valid = mask;
        tick();
        cmd_valid = '0;
        run = mask;
        for (int c = 0; c < CH; c++) if (mask[c]) m_state[c] = M_RUN;
        step = 0;
        poke_ok = 1'b0;
        psel = 0;
        pdata = 0;
        while (run != '0) begin
            if (step >= 1000) begin
                tests++;
                fails++;
                $display("FAIL sweep_budget: running=%b after %0d cycles, required 0", run, step);
                break;
            end
            for (int c = 0; c < CH; c++) begin
                if (run[c]) begin
                    check("addr_valid", 32'(addr_valid[c]), 32'd1);
                    check("addr", 32'(addr[c*A +: A]), 32'(exp_q[c][0]));
                    check("last", 32'(last[c]), 32'(exp_q[c].size() == 1));
                    check("done_low", 32'(done[c]), 32'd0);
                end
            end
            adv = '0;
            for (int c = 0; c < CH; c++) begin
                if (run[c]) adv[c] = rand_adv ? 1'($urandom_range(0, 1)) : 1'b1;
                cmd_op[2*c +: 2] = adv[c] ? OP_ADV : 2'($urandom_range(0, 3));
            end
            cmd_valid = adv;
            poke = (step == poke_at);
            if (poke) begin
                psel     = $urandom_range(0, 6);
                pdata    = $urandom_range(0, 127);
                poke_ok  = cfg_ok(0, psel);
                cfg_we   = 1'b1;
                cfg_ch   = 1'b0;
                cfg_sel  = 3'(psel);
                cfg_data = A'(pdata);
            end
            tick();
            cmd_valid = '0;
            cfg_we    = 1'b0;
            if (poke) begin
                check("cfg_err_run", 32'(cfg_err), 32'(!poke_ok));
                if (poke_ok) cfg_apply(0, psel, pdata);
            end
            for (int c = 0; c < CH; c++) begin
                if (adv[c]) begin
                    if (exp_q[c].size() == 1) begin
                        fin = exp_q[c].pop_front();
                        check("done_pulse", 32'(done[c]), 32'd1);
                        check("valid_after_done", 32'(addr_valid[c]), 32'd0);
                        check("last_after_done", 32'(last[c]), 32'd0);
                        check("addr_hold", 32'(addr[c*A +: A]), 32'(fin));
                        run[c] = 1'b0;
                        m_state[c] = M_DONE;
                    end else begin
                        void'(exp_q[c].pop_front());
                    end
                end
            end
            step++;
        end
        tick();
        for (int c = 0; c < CH; c++)
            if (mask[c]) check("done_one_cycle", 32'(done[c]), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0;
        cmd_valid = '0; cmd_op = '0;
        m_reset();
        repeat (3) tick();
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_addr_valid", 32'(addr_valid), 32'd0);
        check("rst_last", 32'(last), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
        RST_N = 1'b1;
        tick();

        // 4x2 grid, pitch 8: 0,1,2,3,8,9,10,11
        setup(0, 8, 1, 1, 3, 1, 0, 0);
        sweep(2'b01, 1'b0, -1);

        // stride 2 in both directions: 0,2,16,18
        setup(0, 8, 2, 2, 3, 3, 0, 0);
        sweep(2'b01, 1'b0, -1);

        // ch1 with offsets (first address 10) alongside a ch0 sweep
        setup(0, 8, 1, 1, 3, 1, 0, 0);
        setup(1, 8, 1, 1, 1, 1, 1, 2);
        sweep(2'b11, 1'b1, -1);

        // address wraps modulo 2^A: 100, then 200 mod 128 = 72
        setup(1, 100, 1, 1, 0, 1, 1, 0);
        sweep(2'b10, 1'b0, -1);

        // config write while ch0 is running is rejected
        setup(0, 8, 1, 1, 3, 1, 0, 0);
        sweep(2'b01, 1'b0, 2);

        // reserved select is rejected
        cfg_write(0, 7, 5);

        // restart, abort, and ADV outside RUN
        cmd(0, OP_START);
        check("start_valid", 32'(addr_valid[0]), 32'd1);
        check("start_addr", 32'(addr[0 +: A]), 32'd0);
        cmd(0, OP_ADV);
        cmd(0, OP_ADV);
        check("adv2_addr", 32'(addr[0 +: A]), 32'd2);
        cmd(0, OP_START);
        check("restart_addr", 32'(addr[0 +: A]), 32'd0);
        check("restart_valid", 32'(addr_valid[0]), 32'd1);
        cmd(0, OP_ABORT);
        check("abort_valid", 32'(addr_valid[0]), 32'd0);
        check("abort_last", 32'(last[0]), 32'd0);
        check("abort_done", 32'(done[0]), 32'd0);
        cmd(0, OP_ADV);
        check("idle_adv_valid", 32'(addr_valid[0]), 32'd0);
        check("idle_adv_done", 32'(done[0]), 32'd0);

        // START together with a ROW_OFST write: START sees the old offset
        cfg_we = 1'b1; cfg_ch = 1'b0; cfg_sel = 3'd5; cfg_data = A'(1);
        cmd_op[1:0] = OP_START; cmd_valid[0] = 1'b1;
        tick();
        cfg_we = 1'b0; cmd_valid = '0;
        check("same_cycle_cfg_err", 32'(cfg_err), 32'd0);
        check("same_cycle_addr", 32'(addr[0 +: A]), 32'd0);
        check("same_cycle_valid", 32'(addr_valid[0]), 32'd1);
        cfg_apply(0, 5, 1);
        m_state[0] = M_RUN;
        cmd(0, OP_ABORT);
        sweep(2'b01, 1'b0, -1);

        // randomized configurations and advance patterns
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < CH; c++)
                setup(c, $urandom_range(0, 127), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 9), $urandom_range(0, 9),
                      $urandom_range(0, 3), $urandom_range(0, 3));
            sweep(2'b11, 1'b1, (k % 2 == 0) ? 1 : -1);
        end

        // reset in the middle of a sweep, with a rejectable write pending
        setup(0, 8, 1, 1, 3, 1, 0, 0);
        setup(1, 8, 1, 1, 1, 1, 1, 2);
        cmd(0, OP_START);
        cmd(1, OP_START);
        cmd(0, OP_ADV);
        RST_N = 1'b0;
        cfg_we = 1'b1; cfg_ch = 1'b0; cfg_sel = 3'd7;
        tick();
        cfg_we = 1'b0;
        check("midrst_addr", 32'(addr), 32'd0);
        check("midrst_addr_valid", 32'(addr_valid), 32'd0);
        check("midrst_last", 32'(last), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_cfg_err", 32'(cfg_err), 32'd0);
        RST_N = 1'b1;
        m_reset();
        tick();
        // reset configuration gives a single-point sweep at address 0
        sweep(2'b11, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
